// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg - Imem geometry constants and header validation shared by the loader
package imem_loader_pkg;

    localparam int IMEM_SIZE       = 1024;
    localparam int IMEM_ADDR_WIDTH = 10;
    localparam int MAX_WORDS       = IMEM_SIZE / 4;

    // A header word count is usable only if it is non-zero and fits in Imem.
    function automatic logic header_ok(input logic [15:0] n);
        return (n != 16'd0) && (32'(n) <= MAX_WORDS);
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// imem_loader_word_assembler - packs four stream bytes into one big-endian 32-bit word
//
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   clear        drop any partially assembled word (new load)
//   in_valid     in_data is consumed this cycle
//   in_data      stream byte, first byte of a word lands in word[31:24]
//   word_valid   high in the cycle the fourth byte is consumed
//   word         assembled word, valid with word_valid
module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;

    // The fourth byte bypasses the shift register so the word is ready on its accept edge.
    assign word_valid = in_valid && (cnt_q == 2'd3);
    assign word       = {shift_q, in_data};

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear) begin
            shift_d = 24'd0;
            cnt_d   = 2'd0;
        end else if (in_valid) begin
            shift_d = {shift_q[15:0], in_data};
            cnt_d   = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= 24'd0;
            cnt_q   <= 2'd0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader - boot-time framed byte stream to Imem writer with checksum gate on cpu_hold
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   start              one-cycle pulse, begins a load from IDLE/DONE/ERR
//   byte_valid/data    host byte stream; transfer when byte_valid & byte_ready
//   byte_ready         high while a load is consuming bytes
//   we, waddr, wdata   Imem write port, one-cycle we pulse per word
//   busy, done, err    load status (done/err sticky until next start)
//   cpu_hold           keeps the core in reset until a verified image is stored
module imem_loader
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_hold
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  hdr_hi_q, hdr_hi_d;
    logic [15:0] nwords_q, nwords_d;
    logic [15:0] widx_q, widx_d;
    logic [7:0]  csum_q, csum_d;
    logic        we_q, we_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        hold_q, hold_d;

    logic        accept;
    logic        start_ok;
    logic        word_valid;
    logic [31:0] word;

    assign byte_ready = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                        (state_q == S_DATA)   || (state_q == S_CSUM);
    assign accept     = byte_valid && byte_ready;
    assign start_ok   = start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));

    word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .in_valid   (accept && (state_q == S_DATA)),
        .in_data    (byte_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d  = state_q;
        hdr_hi_d = hdr_hi_q;
        nwords_d = nwords_q;
        widx_d   = widx_q;
        csum_d   = csum_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        hold_d   = hold_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_ok) begin
                    state_d  = S_HDR_HI;
                    nwords_d = 16'd0;
                    widx_d   = 16'd0;
                    csum_d   = 8'd0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    hold_d   = 1'b1;
                end
            end
            S_HDR_HI: begin
                if (accept) begin
                    hdr_hi_d = byte_data;
                    state_d  = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (accept) begin
                    nwords_d = {hdr_hi_q, byte_data};
                    if (header_ok({hdr_hi_q, byte_data})) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d = csum_q + byte_data;
                    if (word_valid) begin
                        we_d    = 1'b1;
                        wdata_d = word;
                        waddr_d = {{(32 - IMEM_ADDR_WIDTH){1'b0}},
                                   widx_q[IMEM_ADDR_WIDTH-3:0], 2'b00};
                        widx_d  = widx_q + 16'd1;
                        if (widx_q == nwords_q - 16'd1) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    busy_d = 1'b0;
                    if (byte_data == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            hdr_hi_q <= 8'd0;
            nwords_q <= 16'd0;
            widx_q   <= 16'd0;
            csum_q   <= 8'd0;
            we_q     <= 1'b0;
            waddr_q  <= 32'd0;
            wdata_q  <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            hold_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            hdr_hi_q <= hdr_hi_d;
            nwords_q <= nwords_d;
            widx_q   <= widx_d;
            csum_q   <= csum_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            hold_q   <= hold_d;
        end
    end

    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign cpu_hold = hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader against a queue-based image model
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_hold;

    int tests = 0;
    int fails = 0;

    logic [31:0] img_q[$];
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cpu_hold   (cpu_hold)
    );

    always #5 clk = ~clk;

    // Every cycle with we high is one Imem write; a stretched pulse shows up as an extra entry.
    always @(negedge clk) begin
        if (rst && we) begin
            obs_addr.push_back(waddr);
            obs_data.push_back(wdata);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_we", 32'(we), 32'd0);
        check("rst_waddr", waddr, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    endtask

    // Offer one byte after a random idle gap and hold it until the loader takes it.
    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int gap;
        int n;
        gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        repeat (gap) begin
            @(negedge clk);
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (!byte_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("byte_ready_wait", 32'(byte_ready), 32'd1);
        @(posedge clk);
    endtask

    // start is offered together with a junk byte, which the loader must not consume.
    task automatic pulse_start();
        @(negedge clk);
        start      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'($urandom);
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_cpu_hold", 32'(cpu_hold), 32'd1);
    endtask

    task automatic run_image(input logic [7:0] csum_xor, input int maxgap, input bit mid_start);
        int nw;
        int sum;
        logic [7:0] b;
        bit ok;
        nw  = img_q.size();
        sum = 0;
        obs_addr.delete();
        obs_data.delete();
        pulse_start();
        send_byte(8'(nw >> 8), maxgap);
        send_byte(8'(nw), maxgap);
        for (int k = 0; k < nw; k++) begin
            for (int i = 0; i < 4; i++) begin
                b   = 8'(img_q[k] >> (24 - 8 * i));
                sum = (sum + int'(b)) % 256;
                send_byte(b, maxgap);
                if (mid_start && k == 0 && i == 1) begin
                    @(negedge clk);
                    byte_valid = 1'b0;
                    start      = 1'b1;
                    @(negedge clk);
                    start      = 1'b0;
                    check("mid_start_busy", 32'(busy), 32'd1);
                end
            end
        end
        send_byte(8'(sum) ^ csum_xor, maxgap);
        @(negedge clk);
        byte_valid = 1'b0;
        ok = (csum_xor == 8'd0);
        check("write_count", 32'(obs_addr.size()), 32'(nw));
        for (int k = 0; k < nw && k < obs_addr.size(); k++) begin
            check("write_addr", obs_addr[k], 32'(k * 4));
            check("write_data", obs_data[k], img_q[k]);
        end
        check("end_done", 32'(done), 32'(ok));
        check("end_err", 32'(err), 32'(!ok));
        check("end_cpu_hold", 32'(cpu_hold), 32'(!ok));
        check("end_busy", 32'(busy), 32'd0);
        check("end_byte_ready", 32'(byte_ready), 32'd0);
    endtask

    task automatic hdr_err(input logic [15:0] n);
        obs_addr.delete();
        obs_data.delete();
        pulse_start();
        send_byte(n[15:8], 0);
        send_byte(n[7:0], 0);
        @(negedge clk);
        byte_valid = 1'b0;
        check("hdr_err_err", 32'(err), 32'd1);
        check("hdr_err_done", 32'(done), 32'd0);
        check("hdr_err_busy", 32'(busy), 32'd0);
        check("hdr_err_cpu_hold", 32'(cpu_hold), 32'd1);
        repeat (4) @(negedge clk);
        check("hdr_err_no_write", 32'(obs_addr.size()), 32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b1;
        @(negedge clk);

        // Directed two-word image; its checksum works out to B8.
        img_q = '{32'h3C180007, 32'h3C190008};
        run_image(8'h00, 0, 1'b0);
        run_image(8'h01, 0, 1'b0);

        // Oversized and empty headers.
        hdr_err(16'h0101);
        hdr_err(16'h0000);

        // Full-size random image with gaps on the byte link.
        img_q.delete();
        for (int k = 0; k < 256; k++) img_q.push_back($urandom);
        run_image(8'h00, 3, 1'b0);
        check("full_last_addr", obs_addr.size() == 256 ? obs_addr[255] : 32'hFFFF_FFFF, 32'h3FC);

        // Reset in the middle of a word, then a clean one-word load with a stray start.
        obs_addr.delete();
        obs_data.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hA5, 1);
        send_byte(8'h5A, 1);
        @(negedge clk);
        byte_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_vals();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("mid_reset_no_write", 32'(obs_addr.size()), 32'd0);
        img_q = '{$urandom};
        run_image(8'h00, 2, 1'b1);
        check("done_err_exclusive", 32'(done & err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
